spikey_spi_shift: RTL

SPIKEY_SPI_SHIFT -- requirements
Module: spikey_spi_shift

---
 rtl/spikey_spi_shift.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/spikey_spi_shift.sv
// SPI mode-0 master shifter: one DW-bit full-duplex transfer per handshake, MSB first.
// The SCK half-period comes from the selected bit of an upstream free-running divider.
module spikey_spi_shift #(
  parameter int DW = 8
) (
  input  logic          FCLK,
  input  logic          RST,
  input  logic [3:0]    fclk_div,
  input  logic [1:0]    div_sel,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          busy,
  output logic          SCK,
  output logic          MOSI,
  input  logic          MISO,
  output logic          CS_N
);

  localparam int CW = (DW > 2) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [3:0]    fclk_div_q;
  logic [1:0]    sel_reg, sel_next;
  logic          sck_reg, sck_next;
  logic          mosi_reg, mosi_next;
  logic          cs_n_reg, cs_n_next;
  logic [DW-1:0] tx_shift_reg, tx_shift_next;
  logic [DW-1:0] rx_shift_reg, rx_shift_next;
  logic [DW-1:0] rx_data_reg, rx_data_next;
  logic          rx_valid_reg, rx_valid_next;
  logic [CW-1:0] bitcnt_reg, bitcnt_next;
  logic          tick;

  // An edge on the selected divider bit marks one SCK half-period.
  assign tick = fclk_div[sel_reg] ^ fclk_div_q[sel_reg];

  assign tx_ready = (state_reg == IDLE) && !RST;
  assign busy     = (state_reg != IDLE);
  assign SCK      = sck_reg;
  assign MOSI     = mosi_reg;
  assign CS_N     = cs_n_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;

  always_comb begin
    state_next    = state_reg;
    sel_next      = sel_reg;
    sck_next      = sck_reg;
    mosi_next     = mosi_reg;
    cs_n_next     = cs_n_reg;
    tx_shift_next = tx_shift_reg;
    rx_shift_next = rx_shift_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    bitcnt_next   = bitcnt_reg;

    case (state_reg)
      IDLE: begin
        if (tx_valid) begin
          tx_shift_next = tx_data;
          mosi_next     = tx_data[DW-1];
          cs_n_next     = 1'b0;
          bitcnt_next   = LAST_BIT;
          sel_next      = div_sel;
          state_next    = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sck_reg) begin
            sck_next      = 1'b1;
            rx_shift_next = {rx_shift_reg[DW-2:0], MISO};
          end else begin
            sck_next = 1'b0;
            if (bitcnt_reg != '0) begin
              tx_shift_next = {tx_shift_reg[DW-2:0], 1'b0};
              mosi_next     = tx_shift_reg[DW-2];
              bitcnt_next   = bitcnt_reg - 1'b1;
            end else begin
              state_next = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          cs_n_next     = 1'b1;
          mosi_next     = 1'b0;
          rx_data_next  = rx_shift_reg;
          rx_valid_next = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge FCLK) begin
    fclk_div_q <= fclk_div;
    if (RST) begin
      state_reg    <= IDLE;
      sel_reg      <= '0;
      sck_reg      <= 1'b0;
      mosi_reg     <= 1'b0;
      cs_n_reg     <= 1'b1;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      bitcnt_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      sel_reg      <= sel_next;
      sck_reg      <= sck_next;
      mosi_reg     <= mosi_next;
      cs_n_reg     <= cs_n_next;
      tx_shift_reg <= tx_shift_next;
      rx_shift_reg <= rx_shift_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      bitcnt_reg   <= bitcnt_next;
    end
  end

endmodule
